opb_sys_ctrl: RTL and testbench



---
 rtl/opb_sys_ctrl_pkg.sv | 19 +
 rtl/opb_sys_irq_ctrl.sv | 45 ++++
 rtl/opb_sys_ctrl.sv | 154 +++++++++++++++
 tb/tb_opb_sys_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_sys_ctrl_pkg.sv
// opb_sys_ctrl_pkg: register offsets, bus FSM states and ID word packing for opb_sys_ctrl.
package opb_sys_ctrl_pkg;
    localparam logic [7:0] OFF_ID          = 8'h00;
    localparam logic [7:0] OFF_RCS         = 8'h04;
    localparam logic [7:0] OFF_SRST        = 8'h08;
    localparam logic [7:0] OFF_CYCLES      = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STATUS  = 8'h10;
    localparam logic [7:0] OFF_IRQ_ENABLE  = 8'h14;
    localparam logic [7:0] OFF_IRQ_PENDING = 8'h18;
    localparam logic [7:0] OFF_IRQ_FORCE   = 8'h1C;
    localparam logic [7:0] OFF_SCRATCH     = 8'h20;

    typedef enum logic {ST_IDLE, ST_ACK} bus_state_e;

    function automatic logic [31:0] id_word(input logic [15:0] board, input logic [7:0] major,
                                            input logic [7:0] minor);
        return {board, major, minor};
    endfunction
endpackage

// File: rtl/opb_sys_irq_ctrl.sv
// opb_sys_irq_ctrl: edge-latched interrupt controller with enable, W1C status, force and
// registered active-low irq_n.
module opb_sys_irq_ctrl #(
    parameter int N_IRQ = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] app_irq,
    input  logic [N_IRQ-1:0] w1c,
    input  logic [N_IRQ-1:0] frc,
    input  logic             en_we,
    input  logic [N_IRQ-1:0] en_wdata,
    input  logic [N_IRQ-1:0] en_mask,
    output logic [N_IRQ-1:0] status,
    output logic [N_IRQ-1:0] enable,
    output logic             irq_n
);
    logic [N_IRQ-1:0] prev_q, status_q, status_d, enable_q, enable_d;
    logic             irq_n_q, irq_n_d;

    // Sets are ORed in after the clear so an edge or force beats a simultaneous W1C.
    always_comb begin
        status_d = (status_q & ~w1c) | (app_irq & ~prev_q) | frc;
        enable_d = en_we ? (enable_q & ~en_mask) | (en_wdata & en_mask) : enable_q;
        irq_n_d  = ~|(status_q & enable_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= '0;
            status_q <= '0;
            enable_q <= '0;
            irq_n_q  <= 1'b1;
        end else begin
            prev_q   <= app_irq;
            status_q <= status_d;
            enable_q <= enable_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign status = status_q;
    assign enable = enable_q;
    assign irq_n  = irq_n_q;
endmodule

// File: rtl/opb_sys_ctrl.sv
// opb_sys_ctrl: OPB system-control slave (ID/revision, soft reset, scratch, IRQ controller).
// Define OPB_SYS_CTRL_CYCLE_CNT_EN to build the free-running CYCLES counter.
module opb_sys_ctrl
    import opb_sys_ctrl_pkg::*;
#(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter int                      C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h00000000,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0000FFFF,
    parameter logic [15:0]             BOARD_ID     = 16'hBABE,
    parameter logic [7:0]              REV_MAJOR    = 8'h1,
    parameter logic [7:0]              REV_MINOR    = 8'h0,
    parameter logic [31:0]             REV_RCS      = 32'h0,
    parameter int                      N_IRQ        = 16,
    parameter int                      N_SCRATCH    = 4,
    parameter int                      SRST_LEN     = 16
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [N_IRQ-1:0]        app_irq,
    output logic                    soft_reset,
    output logic                    irq_n
);
    localparam logic [C_OPB_AWIDTH-1:0] SPAN = C_HIGHADDR - C_BASEADDR;

    logic [C_OPB_AWIDTH-1:0] off;
    logic [7:0]              roff;
    logic [3:0]              be;
    logic [31:0]             be_mask, rdata, cycles;
    logic                    hit, in_map;
    bus_state_e              state_q, state_d;
    logic [31:0]             rdata_q, rdata_d, wdata_q, wdata_d, mask_q, mask_d;
    logic                    wr_q, wr_d;
    logic [7:0]              woff_q, woff_d, srst_cnt_q, srst_cnt_d;
    logic [31:0]             scratch_q [N_SCRATCH];
    logic [31:0]             scratch_d [N_SCRATCH];
    logic [N_IRQ-1:0]        status, enable, w1c, frc;
    logic                    en_we, unused_ok;

    // Addresses below the base wrap to huge offsets, so one compare checks both window ends.
    assign off     = OPB_ABus - C_BASEADDR;
    assign hit     = OPB_select && off <= SPAN;
    assign in_map  = off[C_OPB_AWIDTH-1:8] == '0;
    assign roff    = {off[7:2], 2'b00};
    assign be      = OPB_BE;
    assign be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign unused_ok = &{1'b0, OPB_seqAddr, off[1:0]};

`ifdef OPB_SYS_CTRL_CYCLE_CNT_EN
    logic [31:0] cycles_q;
    always_ff @(posedge OPB_Clk) cycles_q <= OPB_Rst ? '0 : cycles_q + 32'd1;
    assign cycles = cycles_q;
`else
    assign cycles = '0;
`endif

    always_comb begin
        rdata = '0;
        case (roff)
            OFF_ID:          rdata = id_word(BOARD_ID, REV_MAJOR, REV_MINOR);
            OFF_RCS:         rdata = REV_RCS;
            OFF_SRST:        rdata = {31'd0, soft_reset};
            OFF_CYCLES:      rdata = cycles;
            OFF_IRQ_STATUS:  rdata = 32'(status);
            OFF_IRQ_ENABLE:  rdata = 32'(enable);
            OFF_IRQ_PENDING: rdata = 32'(status & enable);
            default:         rdata = '0;
        endcase
        for (int k = 0; k < N_SCRATCH; k++)
            if (roff == OFF_SCRATCH + 8'(4 * k)) rdata = scratch_q[k];
        if (!in_map) rdata = '0;
    end

    // The write is captured on the IDLE->ACK edge and applied during the ack cycle.
    always_comb begin
        state_d = ST_IDLE;
        rdata_d = '0;
        wr_d    = 1'b0;
        woff_d  = woff_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        if (state_q == ST_IDLE && hit) begin
            state_d = ST_ACK;
            rdata_d = OPB_RNW ? rdata : '0;
            wr_d    = !OPB_RNW && in_map;
            woff_d  = roff;
            wdata_d = OPB_DBus;
            mask_d  = be_mask;
        end
        srst_cnt_d = (wr_q && woff_q == OFF_SRST && wdata_q[0]) ? 8'(SRST_LEN) :
                     (srst_cnt_q != 8'd0) ? srst_cnt_q - 8'd1 : 8'd0;
        for (int k = 0; k < N_SCRATCH; k++)
            scratch_d[k] = (wr_q && woff_q == OFF_SCRATCH + 8'(4 * k)) ?
                           (scratch_q[k] & ~mask_q) | (wdata_q & mask_q) : scratch_q[k];
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q    <= ST_IDLE;
            rdata_q    <= '0;
            wr_q       <= 1'b0;
            woff_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            srst_cnt_q <= '0;
            for (int k = 0; k < N_SCRATCH; k++) scratch_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            wr_q       <= wr_d;
            woff_q     <= woff_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            srst_cnt_q <= srst_cnt_d;
            scratch_q  <= scratch_d;
        end
    end

    assign w1c   = (wr_q && woff_q == OFF_IRQ_STATUS) ? wdata_q[N_IRQ-1:0] : '0;
    assign frc   = (wr_q && woff_q == OFF_IRQ_FORCE) ? wdata_q[N_IRQ-1:0] : '0;
    assign en_we = wr_q && woff_q == OFF_IRQ_ENABLE;

    opb_sys_irq_ctrl #(.N_IRQ(N_IRQ)) u_irq (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .app_irq  (app_irq),
        .w1c      (w1c),
        .frc      (frc),
        .en_we    (en_we),
        .en_wdata (wdata_q[N_IRQ-1:0]),
        .en_mask  (mask_q[N_IRQ-1:0]),
        .status   (status),
        .enable   (enable),
        .irq_n    (irq_n)
    );

    assign Sl_DBus    = rdata_q;
    assign Sl_xferAck = state_q == ST_ACK;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign soft_reset = srst_cnt_q != 8'd0;
endmodule

// File: tb/tb_opb_sys_ctrl.sv
// tb_opb_sys_ctrl: scoreboarded bench for opb_sys_ctrl; directed timing checks plus random
// register traffic against a word/byte-level model. Honours OPB_SYS_CTRL_CYCLE_CNT_EN.
module tb_opb_sys_ctrl;
    localparam int          N_IRQ     = 16;
    localparam int          N_SCRATCH = 4;
    localparam int          SRST_LEN  = 16;
    localparam logic [31:0] IRQ_MASK  = 32'h0000FFFF;

    typedef struct {
        logic        cap;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [0:31] abus = '0, dbus = '0, sl_dbus;
    logic [0:3] be = '0;
    logic rnw = 1'b0, sel = 1'b0, seq = 1'b0;
    logic sl_ack, sl_err, sl_retry, sl_tout, soft_reset, irq_n;
    logic [N_IRQ-1:0] app_irq = '0;

    int vectors = 0, miscompares = 0, cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] cap_val = '0;
    int last_ack_cyc = 0, srst_start = 0, srst_len = 0;
    logic srst_prev = 1'b0;

    logic [31:0] m_scratch [N_SCRATCH];
    logic [31:0] m_status, m_enable;
    logic [31:0] raddr [10] = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1C,
                                32'h20, 32'h2C, 32'h30, 32'h80};

    opb_sys_ctrl dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (dbus),
        .OPB_RNW     (rnw),
        .OPB_select  (sel),
        .OPB_seqAddr (seq),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (sl_ack),
        .Sl_errAck   (sl_err),
        .Sl_retry    (sl_retry),
        .Sl_toutSup  (sl_tout),
        .app_irq     (app_irq),
        .soft_reset  (soft_reset),
        .irq_n       (irq_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ack, tracks the soft_reset pulse extent.
    always @(negedge clk) begin
        if (sl_ack) begin
            last_ack_cyc = cyc;
            if (sb.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
                mon_e = sb.pop_front();
                if (mon_e.cap) cap_val = sl_dbus;
                else check(mon_e.name, sl_dbus, mon_e.exp);
            end
        end else if (sl_dbus !== 32'd0) check("dbus_not_acking", sl_dbus, 32'd0);
        if (soft_reset && !srst_prev) srst_start = cyc;
        if (!soft_reset && srst_prev) srst_len = cyc - srst_start;
        srst_prev = soft_reset;
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == 32'h00) return 32'hBABE0100;
        if (a == 32'h10) return m_status;
        if (a == 32'h14) return m_enable;
        if (a == 32'h18) return m_status & m_enable;
        if (a >= 32'h20 && a < 32'h20 + 4 * N_SCRATCH) return m_scratch[(a - 32'h20) / 4];
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] b);
        if (a == 32'h10) m_status = m_status & ~d;
        else if (a == 32'h14) m_enable = merge(m_enable, d, b) & IRQ_MASK;
        else if (a == 32'h1C) m_status = (m_status | d) & IRQ_MASK;
        else if (a >= 32'h20 && a < 32'h20 + 4 * N_SCRATCH)
            m_scratch[(a - 32'h20) / 4] = merge(m_scratch[(a - 32'h20) / 4], d, b);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N_SCRATCH; k++) m_scratch[k] = '0;
        m_status = '0;
        m_enable = '0;
    endfunction

    function automatic void push(input logic cap, input logic [31:0] exp, input string name);
        exp_t e;
        e.cap = cap;
        e.exp = exp;
        e.name = name;
        sb.push_back(e);
    endfunction

    // Select held one cycle; returns in the cycle after the ack.
    task automatic bus(input logic [31:0] a, input logic r, input logic [31:0] d,
                       input logic [3:0] b, input logic [N_IRQ-1:0] irq_at_ack);
        int n = 0;
        abus = a; rnw = r; dbus = d; be = b; sel = 1'b1;
        @(posedge clk); #1;
        sel = 1'b0;
        app_irq = app_irq | irq_at_ack;
        while (!sl_ack && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("ack_latency", 32'(n), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        push(1'b0, exp, name);
        bus(a, 1'b1, 32'h0, 4'h0, '0);
    endtask

    task automatic rd_cap(input logic [31:0] a);
        push(1'b1, 32'h0, "cap");
        bus(a, 1'b1, 32'h0, 4'h0, '0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        push(1'b0, 32'h0, "write_dbus");
        bus(a, 1'b0, d, b, '0);
        model_write(a, d, b);
    endtask

    task automatic wait_srst_low();
        int n = 0;
        while (soft_reset && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("srst_timeout", 32'(n < 64), 32'd1);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack1, ack2, op, k;
        logic [31:0] c1, d, a;
        logic [3:0] b;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_dbus", sl_dbus, 32'h0);
        check("rst_ack", 32'(sl_ack), 32'd0);
        check("rst_soft_reset", 32'(soft_reset), 32'd0);
        check("rst_irq_n", 32'(irq_n), 32'd1);
        check("tied_zero", 32'({sl_err, sl_retry, sl_tout}), 32'd0);
        rst = 1'b0;

        rd(32'h00, 32'hBABE0100, "id");
        rd(32'h04, 32'h0, "rev_rcs");
        rd(32'h40, 32'h0, "unmapped_40");
        rd(32'h30, 32'h0, "unmapped_30");
        wr(32'h24, 32'hDEADBEEF, 4'b0011);
        rd(32'h24, 32'h0000BEEF, "scratch1_be");
        rd(32'h1C, 32'h0, "force_reads_0");

        abus = 32'h0001_0000; rnw = 1'b1; sel = 1'b1;
        @(posedge clk); #1;
        sel = 1'b0;
        check("out_of_window_no_ack", 32'(sl_ack), 32'd0);
        @(posedge clk); #1;

        push(1'b0, 32'hBABE0100, "b2b_0");
        push(1'b0, 32'hBABE0100, "b2b_1");
        abus = 32'h0; rnw = 1'b1; sel = 1'b1;
        @(posedge clk); #1; check("b2b_ack_c1", 32'(sl_ack), 32'd1);
        @(posedge clk); #1; check("b2b_ack_c2", 32'(sl_ack), 32'd0);
        @(posedge clk); #1; check("b2b_ack_c3", 32'(sl_ack), 32'd1);
        sel = 1'b0;
        @(posedge clk); #1; check("b2b_ack_c4", 32'(sl_ack), 32'd0);

        wr(32'h14, 32'h4, 4'hF);
        app_irq[2] = 1'b1;
        @(posedge clk); #1; check("irq_n_t1", 32'(irq_n), 32'd1);
        @(posedge clk); #1; check("irq_n_t2", 32'(irq_n), 32'd0);
        m_status = m_status | 32'h4;
        app_irq[2] = 1'b0;
        rd(32'h18, model_read(32'h18), "pending_after_edge");
        wr(32'h10, 32'h4, 4'h0);
        check("w1c_irq_n_t1", 32'(irq_n), 32'd0);
        @(posedge clk); #1; check("w1c_irq_n_t2", 32'(irq_n), 32'd1);
        rd(32'h18, model_read(32'h18), "pending_after_w1c");

        wr(32'h1C, 32'h8, 4'h0);
        rd(32'h10, model_read(32'h10), "status_forced");
        push(1'b0, 32'h0, "write_dbus");
        bus(32'h10, 1'b0, 32'h8, 4'hF, 16'h0008);
        rd(32'h10, 32'h8, "set_wins_over_w1c");
        wr(32'h10, 32'h8, 4'hF);
        rd(32'h10, model_read(32'h10), "w1c_without_edge");
        app_irq = '0;

        wr(32'h08, 32'h0, 4'hF);
        check("srst_bit0_clear", 32'(soft_reset), 32'd0);
        wr(32'h08, 32'h1, 4'h0);
        ack1 = last_ack_cyc;
        rd(32'h08, 32'h1, "srst_busy");
        wait_srst_low();
        check("srst_start", 32'(srst_start), 32'(ack1 + 1));
        check("srst_len", 32'(srst_len), 32'(SRST_LEN));
        rd(32'h08, 32'h0, "srst_idle");

        wr(32'h08, 32'h1, 4'hF);
        ack1 = last_ack_cyc;
        repeat (8) begin @(posedge clk); #1; end
        wr(32'h08, 32'h1, 4'hF);
        ack2 = last_ack_cyc;
        wait_srst_low();
        check("srst_reload_start", 32'(srst_start), 32'(ack1 + 1));
        check("srst_reload_len", 32'(srst_len), 32'(ack2 - ack1 + SRST_LEN));

        wr(32'h08, 32'h1, 4'hF);
        repeat (3) begin @(posedge clk); #1; end
        check("srst_mid_pulse", 32'(soft_reset), 32'd1);
        abus = 32'h20; rnw = 1'b0; dbus = 32'h12345678; be = 4'hF; sel = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        sel = 1'b0; rst = 1'b0;
        check("rst_drops_srst", 32'(soft_reset), 32'd0);
        check("rst_no_ack", 32'(sl_ack), 32'd0);
        model_reset();
        rd(32'h20, 32'h0, "scratch0_after_rst");
        rd(32'h14, 32'h0, "enable_after_rst");

        rd_cap(32'h0C);
        c1 = cap_val;
        repeat (8) begin @(posedge clk); #1; end
        rd_cap(32'h0C);
`ifdef OPB_SYS_CTRL_CYCLE_CNT_EN
        check("cycles_diff", cap_val - c1, 32'd10);
`else
        check("cycles_diff", cap_val - c1, 32'd0);
        check("cycles_zero", cap_val, 32'd0);
`endif

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 5);
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            k = $urandom_range(0, N_SCRATCH - 1);
            if (op <= 3) begin
                a = (op == 0) ? 32'h20 + 32'(4 * k) : (op == 1) ? 32'h14 : (op == 2) ? 32'h1C : 32'h10;
                wr(a, d, b);
                @(posedge clk); #1;
                check("irq_n_random", 32'(irq_n), 32'(!(|(m_status & m_enable))));
            end else begin
                a = raddr[$urandom_range(0, 9)];
                rd(a, model_read(a), "random_read");
            end
        end
        for (int j = 0; j < N_SCRATCH; j++)
            rd(32'h20 + 32'(4 * j), model_read(32'h20 + 32'(4 * j)), "final_scratch");
        rd(32'h18, model_read(32'h18), "final_pending");

        repeat (2) begin @(posedge clk); #1; end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
